ram16k_dma: RTL and testbench

Bus-master engine that drives the RAM16K data memory's write/read port to perform block fills and block copies without the CPU. It owns the RAM16K `in`/`address`/`load` inputs while busy and reads the RAM's combinational `out`. It sits beside the Hack CPU in the Computer; a mux elsewhere grants the RAM port to this block while `busy` is high.

---
 rtl/ram16k_dma_if.sv | 26 ++
 rtl/ram16k_dma.sv | 172 +++++++++++++++++
 tb/tb_ram16k_dma.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram16k_dma_if.sv
// rtl/ram16k_dma_if.sv - RAM16K port bundle between the DMA engine (master) and the RAM (slave)
//
// ram_address : 14-bit word address driven by the master
// ram_in      : 16-bit write data driven by the master
// ram_load    : write enable driven by the master
// ram_out     : 16-bit combinational read data of ram_address, driven by the RAM
interface ram16k_dma_if;
    logic [13:0] ram_address;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [15:0] ram_out;

    modport master (
        output ram_address,
        output ram_in,
        output ram_load,
        input  ram_out
    );

    modport slave (
        input  ram_address,
        input  ram_in,
        input  ram_load,
        output ram_out
    );
endinterface

// File: rtl/ram16k_dma.sv
// rtl/ram16k_dma.sv - block fill / block copy bus master for the RAM16K data memory
//
// Ports:
//   CLK, RESET_N      : clock, synchronous active-low reset
//   start, mode       : transfer request (sampled in IDLE only), 0 = copy, 1 = fill
//   src, dst          : copy source / destination base word addresses
//   len               : word count, values above 16384 saturate to 16384
//   fill_value        : word written by a fill
//   busy, done        : transfer in progress, one-cycle completion pulse
//   error             : sticky read-back mismatch (verify build only, else 0)
//   ram (master)      : RAM16K address/in/load outputs and combinational out input
//
// Build option: define RAM16K_DMA_VERIFY_EN to read back every written word
// in a CHK cycle and flag mismatches on error.
module ram16k_dma (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              mode,
    input  logic [13:0]       src,
    input  logic [13:0]       dst,
    input  logic [14:0]       len,
    input  logic [15:0]       fill_value,
    output logic              busy,
    output logic              done,
    output logic              error,
    ram16k_dma_if.master      ram
);

`ifdef RAM16K_DMA_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_CHK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;
`endif

    state_t      state_q;
    state_t      state_d;
    logic        mode_q;
    logic [13:0] src_q;
    logic [13:0] dst_q;
    logic [14:0] count_q;
    logic [15:0] data_q;
    logic [14:0] len_sat;

    assign len_sat = (len > 15'd16384) ? 15'd16384 : len;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_sat == 15'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = mode ? S_WR : S_RD;
                    end
                end
            end
            S_RD: state_d = S_WR;
            S_WR: begin
`ifdef RAM16K_DMA_VERIFY_EN
                state_d = S_CHK;
`else
                // count_q still holds the pre-decrement value here
                if (count_q == 15'd1) begin
                    state_d = S_DONE;
                end else begin
                    state_d = mode_q ? S_WR : S_RD;
                end
`endif
            end
`ifdef RAM16K_DMA_VERIFY_EN
            S_CHK: begin
                if (count_q == 15'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = mode_q ? S_WR : S_RD;
                end
            end
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        ram.ram_address = 14'd0;
        ram.ram_in      = data_q;
        ram.ram_load    = 1'b0;
        case (state_q)
            S_RD: begin
                busy            = 1'b1;
                ram.ram_address = src_q;
            end
            S_WR: begin
                busy            = 1'b1;
                ram.ram_address = dst_q;
                ram.ram_load    = 1'b1;
            end
`ifdef RAM16K_DMA_VERIFY_EN
            S_CHK: begin
                busy            = 1'b1;
                // dst_q already advanced; modulo-2^14 subtraction gives the word just written
                ram.ram_address = dst_q - 14'd1;
            end
`endif
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

`ifdef RAM16K_DMA_VERIFY_EN
    logic error_q;
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            mode_q  <= 1'b0;
            src_q   <= 14'd0;
            dst_q   <= 14'd0;
            count_q <= 15'd0;
            data_q  <= 16'd0;
`ifdef RAM16K_DMA_VERIFY_EN
            error_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        src_q   <= src;
                        dst_q   <= dst;
                        count_q <= len_sat;
                        // copies overwrite this in RD before it is ever written out
                        data_q  <= fill_value;
`ifdef RAM16K_DMA_VERIFY_EN
                        error_q <= 1'b0;
`endif
                    end
                end
                S_RD: data_q <= ram.ram_out;
                S_WR: begin
                    count_q <= count_q - 15'd1;
                    src_q   <= src_q + 14'd1;
                    dst_q   <= dst_q + 14'd1;
                end
`ifdef RAM16K_DMA_VERIFY_EN
                S_CHK: begin
                    if (ram.ram_out != data_q) begin
                        error_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram16k_dma.sv
// tb/tb_ram16k_dma.sv - self-checking bench for ram16k_dma with a behavioural RAM16K and memory model
module tb_ram16k_dma;

`ifdef RAM16K_DMA_VERIFY_EN
    localparam int K_COPY = 3;
    localparam int K_FILL = 2;
`else
    localparam int K_COPY = 2;
    localparam int K_FILL = 1;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [13:0] src = 14'd0;
    logic [13:0] dst = 14'd0;
    logic [14:0] len = 15'd0;
    logic [15:0] fill_value = 16'd0;
    logic        busy;
    logic        done;
    logic        error;

    ram16k_dma_if bus ();

    ram16k_dma dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .start      (start),
        .mode       (mode),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .ram        (bus)
    );

    always #5 CLK = ~CLK;

    logic [15:0] mem     [0:16383];
    logic [15:0] exp_mem [0:16383];
    logic        init_req = 1'b0;
    logic [15:0] seed16 = 16'd0;
    logic        drop_en = 1'b0;
    logic [13:0] drop_addr = 14'd0;

    int checks = 0;
    int failures = 0;

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 40503) ^ seed16;
    endfunction

    assign bus.ram_out = mem[bus.ram_address];

    always @(posedge CLK) begin
        if (init_req) begin
            for (int i = 0; i < 16384; i++) mem[i] <= pat(i);
        end else if (bus.ram_load && !(drop_en && bus.ram_address == drop_addr)) begin
            mem[bus.ram_address] <= bus.ram_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic init_mem();
        seed16 = 16'($urandom);
        init_req = 1'b1;
        @(posedge CLK);
        #1;
        init_req = 1'b0;
        for (int i = 0; i < 16384; i++) exp_mem[i] = pat(i);
    endtask

    task automatic model_xfer(input logic m, input logic [13:0] s, input logic [13:0] d,
                              input int n, input logic [15:0] fv);
        for (int i = 0; i < n; i++) begin
            int da;
            int sa;
            da = (int'(d) + i) % 16384;
            sa = (int'(s) + i) % 16384;
            if (!(drop_en && da == int'(drop_addr))) begin
                exp_mem[da] = m ? fv : exp_mem[sa];
            end
        end
    endtask

    task automatic compare_mem(input string tag);
        int diff;
        diff = 0;
        for (int i = 0; i < 16384; i++) begin
            if (mem[i] !== exp_mem[i]) diff++;
        end
        check({tag, "_mem"}, 32'(diff), 32'd0);
    endtask

    task automatic run_xfer(input string tag, input logic m, input logic [13:0] s,
                            input logic [13:0] d, input logic [14:0] l,
                            input logic [15:0] fv, input bit poke, input logic exp_err);
        int n;
        int k;
        int lat;
        int loads;
        n = (l > 15'd16384) ? 16384 : int'(l);
        k = m ? K_FILL : K_COPY;
        mode = m; src = s; dst = d; len = l; fill_value = fv; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), (n > 0) ? 32'd1 : 32'd0);
        check({tag, "_err_clr"}, 32'(error), 32'd0);
        lat = 0;
        loads = 0;
        while (done !== 1'b1 && lat < n * k + 10) begin
            if (bus.ram_load) loads++;
            if (poke && lat == 1) begin
                start = 1'b1; mode = ~m; dst = ~d; len = 15'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK);
            #1;
            lat++;
        end
        start = 1'b0;
        check({tag, "_done_lat"}, 32'(lat), 32'(n * k));
        check({tag, "_loads"}, 32'(loads), 32'(n));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(error), 32'(exp_err));
        model_xfer(m, s, d, n, fv);
        compare_mem(tag);
        @(posedge CLK);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        // reset state
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_load", 32'(bus.ram_load), 32'd0);
        check("rst_addr", 32'(bus.ram_address), 32'd0);
        check("rst_in", 32'(bus.ram_in), 32'd0);
        RESET_N = 1'b1;
        init_mem();

        // fill 0x0100..0x0103, 0x0104 untouched
        run_xfer("fill4", 1'b1, 14'd0, 14'h0100, 15'd4, 16'hBEEF, 1'b0, 1'b0);
        check("fill4_w0", 32'(mem[14'h0100]), 32'hBEEF);
        check("fill4_w3", 32'(mem[14'h0103]), 32'hBEEF);
        check("fill4_next", 32'(mem[14'h0104]), 32'(pat(16'h0104)));

        // seed the copy source with single-word fills, then copy
        run_xfer("seed0", 1'b1, 14'd0, 14'h0010, 15'd1, 16'h0001, 1'b0, 1'b0);
        run_xfer("seed1", 1'b1, 14'd0, 14'h0011, 15'd1, 16'hFFFE, 1'b0, 1'b0);
        run_xfer("seed2", 1'b1, 14'd0, 14'h0012, 15'd1, 16'h7FFF, 1'b0, 1'b0);
        run_xfer("copy3", 1'b0, 14'h0010, 14'h2000, 15'd3, 16'h0000, 1'b0, 1'b0);
        check("copy3_d0", 32'(mem[14'h2000]), 32'h0001);
        check("copy3_d1", 32'(mem[14'h2001]), 32'hFFFE);
        check("copy3_d2", 32'(mem[14'h2002]), 32'h7FFF);
        check("copy3_s1", 32'(mem[14'h0011]), 32'hFFFE);

        // pointer wrap
        run_xfer("wrap", 1'b1, 14'd0, 14'h3FFE, 15'd4, 16'h1234, 1'b0, 1'b0);
        check("wrap_3fff", 32'(mem[14'h3FFF]), 32'h1234);
        check("wrap_0001", 32'(mem[14'h0001]), 32'h1234);

        // zero length and start pulsed while busy
        run_xfer("len0", 1'b0, 14'h0123, 14'h0456, 15'd0, 16'h0000, 1'b0, 1'b0);
        run_xfer("poke", 1'b1, 14'd0, 14'h0300, 15'd6, 16'hC0DE, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge CLK);
            #1;
            check("poke_idle_done", 32'(done), 32'd0);
        end

        // randomized transfers, including overlapping copies
        for (int t = 0; t < 8; t++) begin
            logic        m;
            logic [13:0] s;
            logic [13:0] d;
            m = 1'($urandom);
            s = 14'($urandom);
            d = (t % 2 == 0) ? s + 14'($urandom_range(1, 5)) : 14'($urandom);
            run_xfer("rand", m, s, d, 15'($urandom_range(0, 40)), 16'($urandom), 1'b0, 1'b0);
        end

        // saturated length covers every word once
        run_xfer("full", 1'b1, 14'd0, 14'($urandom), 15'h7FFF, 16'h5A5A, 1'b0, 1'b0);

        // reset in the middle of a copy, right after the second write
        init_mem();
        begin
            int seen;
            int guard;
            mode = 1'b0; src = 14'h0040; dst = 14'h0800; len = 15'd10; start = 1'b1;
            @(posedge CLK);
            #1;
            start = 1'b0;
            seen = 0;
            guard = 0;
            while (seen < 2 && guard < 40) begin
                if (bus.ram_load) seen++;
                if (seen < 2) begin
                    @(posedge CLK);
                    #1;
                end
                guard++;
            end
            check("mid_found", 32'(seen), 32'd2);
            @(posedge CLK);
            #1;
            RESET_N = 1'b0;
            @(posedge CLK);
            #1;
            check("mid_busy", 32'(busy), 32'd0);
            check("mid_done", 32'(done), 32'd0);
            check("mid_load", 32'(bus.ram_load), 32'd0);
            check("mid_addr", 32'(bus.ram_address), 32'd0);
            check("mid_in", 32'(bus.ram_in), 32'd0);
            check("mid_error", 32'(error), 32'd0);
            RESET_N = 1'b1;
            model_xfer(1'b0, 14'h0040, 14'h0800, 2, 16'h0000);
            compare_mem("mid");
        end

`ifdef RAM16K_DMA_VERIFY_EN
        // a dropped write is caught by read-back and stays flagged until the next start
        drop_en = 1'b1;
        drop_addr = 14'h0201;
        run_xfer("drop", 1'b1, 14'd0, 14'h0200, 15'd4, 16'hA5A5, 1'b0, 1'b1);
        drop_en = 1'b0;
        check("drop_sticky", 32'(error), 32'd1);
        run_xfer("after_drop", 1'b0, 14'd0, 14'h0400, 15'd2, 16'h0000, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
